imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time instruction-memory loader that sequences the instruction-fetch stage's IMEM write port. It accepts a byte stream (e.g. from a UART receiver) framed as a 16-bit word count followed by big-endian 32-bit instructions. It drives the fetch stage's write-enable, write-data and next-PC inputs one word per write cycle. It holds the core in reset for the whole load, so the core cannot fetch while memory is being rewritten.

## Interface
Parameters:
- IMEM_SIZE, 64: instruction memory depth in words; the largest legal word count.
- CNT_W, 16: width of the header word count.

Ports:
- CLK  in  1  system clock; all state updates on posedge.
- RST  in  1  asynchronous, active-high reset.
- load_start  in  1  single-cycle request to begin a load; honoured only in IDLE.
- abort  in  1  forces a return to IDLE from any state.
- rx_valid  in  1  byte-stream valid.
- rx_data  in  8  byte-stream data.
- rx_ready  out  1  byte accepted when rx_valid && rx_ready on a posedge.
- we  out  1  to fetch-stage WE.
- w_ins  out  32  to fetch-stage W_Ins.
- w_pc  out  32  byte address, muxed onto fetch-stage newPC while core_rst=1.
- core_rst  out  1  ORed into the core's RST; high while loading.
- busy  out  1  high in any state other than IDLE.
- load_done  out  1  one-cycle pulse on successful completion.
- err  out  1  sticky error flag; cleared when a new load_start is accepted.

## Operation
- States: IDLE, HDR_HI, HDR_LO, RECV, WRITE, DONE, ERR.
- IDLE:
  - rx_ready=0, core_rst=0.
  - On load_start: clear err, clear word_cnt and byte_idx, go to HDR_HI.
- HDR_HI / HDR_LO:
  - rx_ready=1.
  - Capture count[15:8] in HDR_HI and count[7:0] in HDR_LO.
  - On the HDR_LO handshake:
    - count=0 → DONE.
    - count>IMEM_SIZE → ERR, with err=1.
    - otherwise → RECV.
- RECV:
  - rx_ready=1.
  - Each accepted byte shifts into the assembly register, big-endian: the first byte becomes bits [31:24].
  - byte_idx counts 0..3. The 4th handshake → WRITE, and byte_idx wraps to 0.
- WRITE, exactly one cycle:
  - we=1, w_ins=assembled word, w_pc={word_cnt,2'b00} zero-extended to 32 bits, rx_ready=0.
  - word_cnt increments.
  - If the new word_cnt==count → DONE, else → RECV.
- DONE, one cycle: load_done=1, core_rst=1, then → IDLE.
- ERR:
  - rx_ready=0, core_rst=1; incoming bytes are not consumed.
  - Stays in ERR until abort (→ IDLE, err remains 1) or RST.
- abort has priority over every other transition:
  - Next state is IDLE and core_rst drops.
  - Any word already written stays in IMEM.
  - err is unchanged.
- core_rst=1 in every state except IDLE.
  - The fetch stage's PC is therefore held at 0 by its async reset.
  - IMEM writes still proceed, because the fetch stage's write path is not reset-gated.
- Outside WRITE: we=0; w_ins and w_pc hold their last values. They are not required to be zero.
- load_start outside IDLE is ignored.

## Timing
- Reset values: state=IDLE, rx_ready=0, we=0, w_ins=0, w_pc=0, core_rst=0, busy=0, load_done=0, err=0, word_cnt=0, byte_idx=0.
- All outputs are registered, or decoded from the state register only; no rx_valid→rx_ready combinational path.
- load_start sampled at edge k → busy=1 and core_rst=1 from k+1.
- The 4th byte of a word handshakes at edge t:
  - we=1 during cycle t..t+1.
  - The fetch stage writes IMEM on edge t+1.
  - rx_ready returns at t+1.
- Minimum load time for N words with a back-to-back stream: 2 + 5N + 1 cycles. Throughput is 4 bytes per 5 cycles.
- The last WRITE is followed by exactly one DONE cycle; core_rst falls on the edge after DONE, the same edge that returns to IDLE.
- RST mid-load: immediate return to reset values; a partially assembled word is discarded and never written.
- abort asserted in the same cycle as a final-byte handshake: abort wins, no WRITE occurs.

## Structure
- Shared package/header holds:
  - the state encodings (localparam, 3 bits);
  - IMEM_SIZE, taken from the common parameter header already used by the fetch stage, so that loader and memory agree.
- A single flat module with no sub-modules. The byte-to-word shifter is inline, because it is only a 32-bit register plus a 2-bit counter.
- Top level muxes newPC = core_rst ? w_pc : ex_newPC, and drives WE=we, W_Ins=w_ins.

## Test plan
- Nominal load:
  - Stimulus: load_start, then bytes 00 02 | 01 4B 48 20 | 22 51 01 00.
  - Required: two WRITE cycles, (w_pc=0x0, w_ins=0x014B4820) then (w_pc=0x4, w_ins=0x22510100); load_done pulses once.
  - Required: core_rst falls; IMEM[0..1] match the written words; the core fetches 0x014B4820 at PC 0.
- Zero count:
  - Stimulus: header 00 00.
  - Required: DONE on the cycle after the HDR_LO handshake; we never asserted; load_done=1 for one cycle.
- Oversize count:
  - Stimulus: header 00 41 (65 > 64).
  - Required: ERR with err=1, rx_ready=0, core_rst=1; no writes.
  - Then abort → IDLE with err still 1; the next load_start clears err.
- Stalled stream:
  - Stimulus: rx_valid toggles randomly during RECV.
  - Required: each byte is consumed exactly once; word contents match; the WRITE count equals the header count.
- Abort and reset mid-word:
  - Stimulus: abort after 2 of 4 bytes of word 3.
  - Required: IDLE next cycle; no write to address 0xC.
  - Repeat with RST instead of abort: all outputs return to reset values asynchronously.
- Ignored start:
  - Stimulus: load_start pulsed during RECV.
  - Required: no state change; the load completes normally.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared constants and state encoding for the boot-time IMEM loader.
// IMEM_SIZE mirrors the fetch-stage memory depth so loader and memory agree.
package imem_loader_pkg;

  localparam int IMEM_SIZE = 64;
  localparam int CNT_W     = 16;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HDR_HI = 3'd1,
    S_HDR_LO = 3'd2,
    S_RECV   = 3'd3,
    S_WRITE  = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

endpackage

// File: rtl/imem_loader.sv
// Boot loader: turns a framed byte stream (16-bit count + big-endian words)
// into IMEM write cycles while holding the core in reset.
module imem_loader #(
  parameter int IMEM_SIZE = imem_loader_pkg::IMEM_SIZE,
  parameter int CNT_W     = imem_loader_pkg::CNT_W
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        load_start,
  input  logic        abort,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        we,
  output logic [31:0] w_ins,
  output logic [31:0] w_pc,
  output logic        core_rst,
  output logic        busy,
  output logic        load_done,
  output logic        err
);
  import imem_loader_pkg::*;

  localparam logic [CNT_W-1:0] MAX_WORDS = CNT_W'(IMEM_SIZE);

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_word_cnt;
  logic [1:0]       r_byte_idx;
  logic [31:0]      r_shift;

  logic             w_hs;
  logic             w_go;
  logic [CNT_W-1:0] w_hdr_count;
  logic [CNT_W-1:0] w_next_cnt;

  assign w_hs        = rx_valid && rx_ready;
  assign w_go        = w_hs && !abort;
  assign w_hdr_count = {r_count[CNT_W-1:8], rx_data};
  assign w_next_cnt  = r_word_cnt + CNT_W'(1);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Outputs decode from the state register only, so rx_ready never depends on rx_valid.
  always_comb begin
    w_next_state = r_state;
    rx_ready     = 1'b0;
    we           = 1'b0;
    core_rst     = 1'b1;
    busy         = 1'b1;
    load_done    = 1'b0;
    case (r_state)
      S_IDLE: begin
        core_rst = 1'b0;
        busy     = 1'b0;
        if (load_start) w_next_state = S_HDR_HI;
      end
      S_HDR_HI: begin
        rx_ready = 1'b1;
        if (w_hs) w_next_state = S_HDR_LO;
      end
      S_HDR_LO: begin
        rx_ready = 1'b1;
        if (w_hs) begin
          if (w_hdr_count == '0)           w_next_state = S_DONE;
          else if (w_hdr_count > MAX_WORDS) w_next_state = S_ERR;
          else                              w_next_state = S_RECV;
        end
      end
      S_RECV: begin
        rx_ready = 1'b1;
        if (w_hs && r_byte_idx == 2'd3) w_next_state = S_WRITE;
      end
      S_WRITE: begin
        we           = 1'b1;
        w_next_state = (w_next_cnt == r_count) ? S_DONE : S_RECV;
      end
      S_DONE: begin
        load_done    = 1'b1;
        w_next_state = S_IDLE;
      end
      S_ERR: begin
        w_next_state = S_ERR;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
    if (abort) w_next_state = S_IDLE;
  end

  // Datapath: header capture, byte-to-word shifter and write-port registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_count    <= '0;
      r_word_cnt <= '0;
      r_byte_idx <= '0;
      r_shift    <= '0;
      w_ins      <= '0;
      w_pc       <= '0;
      err        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (load_start && !abort) begin
            err        <= 1'b0;
            r_word_cnt <= '0;
            r_byte_idx <= '0;
          end
        end
        S_HDR_HI: begin
          if (w_go) r_count[CNT_W-1:8] <= rx_data;
        end
        S_HDR_LO: begin
          if (w_go) begin
            r_count[7:0] <= rx_data;
            if (w_hdr_count > MAX_WORDS) err <= 1'b1;
          end
        end
        S_RECV: begin
          if (w_go) begin
            r_shift    <= {r_shift[23:0], rx_data};
            r_byte_idx <= r_byte_idx + 2'd1;
            // Latch the write port as the last byte arrives so WRITE presents it immediately.
            if (r_byte_idx == 2'd3) begin
              w_ins <= {r_shift[23:0], rx_data};
              w_pc  <= 32'({r_word_cnt, 2'b00});
            end
          end
        end
        S_WRITE: begin
          r_word_cnt <= w_next_cnt;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader; models the fetch-stage IMEM
// write port and counts handshakes, writes and load_done pulses.
module tb_imem_loader;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        load_start = 1'b0;
  logic        abort = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready;
  logic        we;
  logic [31:0] w_ins;
  logic [31:0] w_pc;
  logic        core_rst;
  logic        busy;
  logic        load_done;
  logic        err;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem    [0:63];
  logic [31:0] logPc  [0:63];
  logic [31:0] logIns [0:63];
  int wrCount = 0;
  int hsCount = 0;
  int ldCount = 0;
  int busyCycles = 0;

  imem_loader dut (
    .CLK(CLK), .RST(RST), .load_start(load_start), .abort(abort),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .we(we), .w_ins(w_ins), .w_pc(w_pc), .core_rst(core_rst),
    .busy(busy), .load_done(load_done), .err(err)
  );

  always #5 CLK = ~CLK;

  // Fetch-stage stand-in: IMEM writes on the edge that ends a we=1 cycle.
  always @(posedge CLK) begin
    if (we) begin
      mem[w_pc[7:2]] <= w_ins;
      if (wrCount < 64) begin
        logPc[wrCount]  <= w_pc;
        logIns[wrCount] <= w_ins;
      end
      wrCount <= wrCount + 1;
    end
    if (rx_valid && rx_ready) hsCount <= hsCount + 1;
    if (load_done) ldCount <= ldCount + 1;
    if (busy) busyCycles <= busyCycles + 1;
  end

  task automatic pulseStart();
    load_start = 1'b1;
    @(negedge CLK);
    load_start = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b);
    int n;
    n = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && n < 40) begin
      @(negedge CLK);
      n++;
    end
    if (!rx_ready) begin
      $display("[TB] FAIL byte_timeout: rx_ready=%0b required 1 for byte %h", rx_ready, b);
      errors++;
    end
    @(negedge CLK);
    rx_valid = 1'b0;
  endtask

  task automatic sendWord(input logic [31:0] w);
    sendByte(w[31:24]);
    sendByte(w[23:16]);
    sendByte(w[15:8]);
    sendByte(w[7:0]);
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while (busy && n < 200) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      $display("[TB] FAIL idle_timeout: busy=%0b required 0", busy);
      errors++;
    end
  endtask

  task automatic test_reset();
    @(negedge CLK);
    checks++;
    if ({rx_ready, we, core_rst, busy, load_done, err} !== 6'b0) begin
      $display("[TB] FAIL reset_flags: got %b required 000000", {rx_ready, we, core_rst, busy, load_done, err});
      errors++;
    end
    checks++;
    if (w_ins !== 32'h0 || w_pc !== 32'h0) begin
      $display("[TB] FAIL reset_bus: w_ins=%h w_pc=%h required 0/0", w_ins, w_pc);
      errors++;
    end
    RST = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_nominal();
    int wr0, ld0, bc0;
    wr0 = wrCount; ld0 = ldCount; bc0 = busyCycles;
    pulseStart();
    checks++;
    if (busy !== 1'b1 || core_rst !== 1'b1) begin
      $display("[TB] FAIL start_busy: busy=%0b core_rst=%0b required 1/1", busy, core_rst);
      errors++;
    end
    sendByte(8'h00); sendByte(8'h02);
    sendWord(32'h014B4820);
    sendWord(32'h22510100);
    checks++;
    if (we !== 1'b1 || w_pc !== 32'h4 || w_ins !== 32'h22510100) begin
      $display("[TB] FAIL nominal_write1: we=%0b pc=%h ins=%h required 1/4/22510100", we, w_pc, w_ins);
      errors++;
    end
    @(negedge CLK);
    checks++;
    if (load_done !== 1'b1 || core_rst !== 1'b1) begin
      $display("[TB] FAIL nominal_done: load_done=%0b core_rst=%0b required 1/1", load_done, core_rst);
      errors++;
    end
    @(negedge CLK);
    checks++;
    if (core_rst !== 1'b0 || busy !== 1'b0 || load_done !== 1'b0) begin
      $display("[TB] FAIL nominal_release: core_rst=%0b busy=%0b load_done=%0b required 0/0/0", core_rst, busy, load_done);
      errors++;
    end
    checks++;
    if (wrCount - wr0 !== 2 || logPc[wr0] !== 32'h0 || logIns[wr0] !== 32'h014B4820) begin
      $display("[TB] FAIL nominal_write0: writes=%0d pc=%h ins=%h required 2/0/014B4820", wrCount - wr0, logPc[wr0], logIns[wr0]);
      errors++;
    end
    checks++;
    if (mem[0] !== 32'h014B4820 || mem[1] !== 32'h22510100) begin
      $display("[TB] FAIL nominal_imem: mem0=%h mem1=%h required 014B4820/22510100", mem[0], mem[1]);
      errors++;
    end
    checks++;
    if (ldCount - ld0 !== 1) begin
      $display("[TB] FAIL nominal_done_count: got %0d required 1", ldCount - ld0);
      errors++;
    end
    checks++;
    if (busyCycles - bc0 !== 13) begin
      $display("[TB] FAIL nominal_load_time: got %0d cycles required 13", busyCycles - bc0);
      errors++;
    end
  endtask

  task automatic test_zero_count();
    int wr0, ld0;
    wr0 = wrCount; ld0 = ldCount;
    pulseStart();
    sendByte(8'h00); sendByte(8'h00);
    checks++;
    if (load_done !== 1'b1 || we !== 1'b0) begin
      $display("[TB] FAIL zero_done: load_done=%0b we=%0b required 1/0", load_done, we);
      errors++;
    end
    @(negedge CLK);
    checks++;
    if (busy !== 1'b0 || wrCount - wr0 !== 0 || ldCount - ld0 !== 1) begin
      $display("[TB] FAIL zero_end: busy=%0b writes=%0d dones=%0d required 0/0/1", busy, wrCount - wr0, ldCount - ld0);
      errors++;
    end
  endtask

  task automatic test_oversize();
    int wr0, hs0;
    wr0 = wrCount;
    pulseStart();
    sendByte(8'h00); sendByte(8'h41);
    checks++;
    if (err !== 1'b1 || rx_ready !== 1'b0 || core_rst !== 1'b1 || busy !== 1'b1) begin
      $display("[TB] FAIL oversize_err: err=%0b rx_ready=%0b core_rst=%0b busy=%0b required 1/0/1/1", err, rx_ready, core_rst, busy);
      errors++;
    end
    hs0 = hsCount;
    rx_valid = 1'b1; rx_data = 8'hAA;
    repeat (4) @(negedge CLK);
    rx_valid = 1'b0;
    checks++;
    if (hsCount - hs0 !== 0 || wrCount - wr0 !== 0 || busy !== 1'b1) begin
      $display("[TB] FAIL oversize_hold: handshakes=%0d writes=%0d busy=%0b required 0/0/1", hsCount - hs0, wrCount - wr0, busy);
      errors++;
    end
    abort = 1'b1;
    @(negedge CLK);
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || core_rst !== 1'b0 || err !== 1'b1) begin
      $display("[TB] FAIL oversize_abort: busy=%0b core_rst=%0b err=%0b required 0/0/1", busy, core_rst, err);
      errors++;
    end
    pulseStart();
    checks++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      $display("[TB] FAIL oversize_clear: err=%0b busy=%0b required 0/1", err, busy);
      errors++;
    end
    abort = 1'b1;
    @(negedge CLK);
    abort = 1'b0;
  endtask

  task automatic test_stalled();
    logic [31:0] words [0:2];
    int wr0, hs0, ld0;
    words[0] = 32'hDEADBEEF; words[1] = 32'h00000001; words[2] = 32'h8000007F;
    wr0 = wrCount; hs0 = hsCount; ld0 = ldCount;
    pulseStart();
    sendByte(8'h00); sendByte(8'h03);
    for (int w = 0; w < 3; w++) begin
      for (int b = 3; b >= 0; b--) begin
        repeat ($urandom_range(0, 2)) begin
          rx_data = 8'h5A;
          @(negedge CLK);
        end
        sendByte(words[w][b*8 +: 8]);
      end
    end
    waitIdle();
    checks++;
    if (hsCount - hs0 !== 14 || wrCount - wr0 !== 3 || ldCount - ld0 !== 1) begin
      $display("[TB] FAIL stall_counts: handshakes=%0d writes=%0d dones=%0d required 14/3/1", hsCount - hs0, wrCount - wr0, ldCount - ld0);
      errors++;
    end
    for (int w = 0; w < 3; w++) begin
      checks++;
      if (logIns[wr0 + w] !== words[w] || logPc[wr0 + w] !== 32'(w * 4)) begin
        $display("[TB] FAIL stall_word%0d: ins=%h pc=%h required %h/%h", w, logIns[wr0 + w], logPc[wr0 + w], words[w], w * 4);
        errors++;
      end
    end
  endtask

  task automatic test_abort_mid_word();
    int wr0;
    wr0 = wrCount;
    pulseStart();
    sendByte(8'h00); sendByte(8'h04);
    sendWord(32'h11111111); sendWord(32'h22222222); sendWord(32'h33333333);
    sendByte(8'h44); sendByte(8'h44);
    abort = 1'b1;
    @(negedge CLK);
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || core_rst !== 1'b0) begin
      $display("[TB] FAIL abort_idle: busy=%0b core_rst=%0b required 0/0", busy, core_rst);
      errors++;
    end
    repeat (3) @(negedge CLK);
    checks++;
    if (wrCount - wr0 !== 3 || logPc[wr0 + 2] !== 32'h8 || mem[2] !== 32'h33333333) begin
      $display("[TB] FAIL abort_writes: writes=%0d lastpc=%h mem2=%h required 3/8/33333333", wrCount - wr0, logPc[wr0 + 2], mem[2]);
      errors++;
    end
    // Abort coincident with a final-byte handshake must suppress the write.
    wr0 = wrCount;
    pulseStart();
    sendByte(8'h00); sendByte(8'h01);
    sendByte(8'h99); sendByte(8'h88); sendByte(8'h77);
    rx_valid = 1'b1; rx_data = 8'h66; abort = 1'b1;
    @(negedge CLK);
    rx_valid = 1'b0; abort = 1'b0;
    repeat (2) @(negedge CLK);
    checks++;
    if (busy !== 1'b0 || wrCount - wr0 !== 0) begin
      $display("[TB] FAIL abort_final_byte: busy=%0b writes=%0d required 0/0", busy, wrCount - wr0);
      errors++;
    end
  endtask

  task automatic test_rst_mid_word();
    int wr0;
    wr0 = wrCount;
    pulseStart();
    sendByte(8'h00); sendByte(8'h02);
    sendWord(32'hCAFEF00D);
    sendByte(8'h12); sendByte(8'h34);
    #2 RST = 1'b1;
    #1;
    checks++;
    if ({rx_ready, we, core_rst, busy, load_done, err} !== 6'b0 || w_ins !== 32'h0 || w_pc !== 32'h0) begin
      $display("[TB] FAIL rst_async: flags=%b w_ins=%h w_pc=%h required 000000/0/0", {rx_ready, we, core_rst, busy, load_done, err}, w_ins, w_pc);
      errors++;
    end
    @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    checks++;
    if (wrCount - wr0 !== 1 || busy !== 1'b0) begin
      $display("[TB] FAIL rst_writes: writes=%0d busy=%0b required 1/0", wrCount - wr0, busy);
      errors++;
    end
  endtask

  task automatic test_ignored_start();
    int wr0, ld0;
    wr0 = wrCount; ld0 = ldCount;
    pulseStart();
    sendByte(8'h00); sendByte(8'h01);
    sendByte(8'hA1); sendByte(8'hB2);
    pulseStart();
    checks++;
    if (rx_ready !== 1'b1 || busy !== 1'b1) begin
      $display("[TB] FAIL ignore_state: rx_ready=%0b busy=%0b required 1/1", rx_ready, busy);
      errors++;
    end
    sendByte(8'hC3); sendByte(8'hD4);
    waitIdle();
    checks++;
    if (wrCount - wr0 !== 1 || logIns[wr0] !== 32'hA1B2C3D4 || logPc[wr0] !== 32'h0 || ldCount - ld0 !== 1) begin
      $display("[TB] FAIL ignore_load: writes=%0d ins=%h pc=%h dones=%0d required 1/A1B2C3D4/0/1", wrCount - wr0, logIns[wr0], logPc[wr0], ldCount - ld0);
      errors++;
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_zero_count();
    test_oversize();
    test_stalled();
    test_abort_mid_word();
    test_rst_mid_word();
    test_ignored_start();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
